// File: rtl/async_fifo_write_control.sv
// Write-domain half of the dual-clock FIFO: write pointer, read-pointer synchroniser
// and registered, conservative full / almostFull / freeCount status.
module async_fifo_write_control #(
   parameter int DATADEPTH       = 8,
   parameter int ADDRESSWIDTH    = $clog2(DATADEPTH),
   parameter int SYNCSTAGES      = 2,
   parameter int ALMOSTFULLLEVEL = 2
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    writeReq,
   input  logic [ADDRESSWIDTH:0]   readPointerGray,
   output logic                    writeEn,
   output logic [ADDRESSWIDTH-1:0] writeAddress,
   output logic [ADDRESSWIDTH:0]   writePointerGray,
   output logic                    full,
   output logic                    almostFull,
   output logic [ADDRESSWIDTH:0]   freeCount
);
   localparam int PW = ADDRESSWIDTH + 1;
   localparam logic [PW-1:0] DEPTHVAL = PW'(DATADEPTH);
   localparam logic [PW-1:0] AFLEVEL  = PW'(ALMOSTFULLLEVEL);
   // Full when the write Gray pointer equals the read one with its two MSBs inverted
   // (for a 2-bit pointer that is both bits).
   localparam logic [PW-1:0] FULLMASK = PW'(2'b11) << (PW - 2);

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b = g;
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0] wbinR;
   logic [PW-1:0] wgrayR;
   logic [PW-1:0] syncR [SYNCSTAGES];
   logic [PW-1:0] rgraySyncS;
   logic [PW-1:0] rbinSyncS;
   logic [PW-1:0] wbinNextS;
   logic [PW-1:0] wgrayNextS;
   logic [PW-1:0] freeNextS;
   logic          fullR;
   logic          almostFullR;
   logic [PW-1:0] freeCountR;

   // Gating with resetN keeps writeEn low for the whole reset, whatever writeReq does.
   assign writeEn          = writeReq & ~fullR & resetN;
   assign writeAddress     = wbinR[ADDRESSWIDTH-1:0];
   assign writePointerGray = wgrayR;
   assign full             = fullR;
   assign almostFull       = almostFullR;
   assign freeCount        = freeCountR;

   assign rgraySyncS = syncR[SYNCSTAGES-1];
   assign rbinSyncS  = gray2bin(rgraySyncS);

   // Next write pointer and the free space it would leave against the synchronised read pointer.
   always_comb begin
      wbinNextS = wbinR;
      if (writeEn) begin
         wbinNextS = wbinR + PW'(1);
      end else begin
         wbinNextS = wbinR;
      end
      wgrayNextS = bin2gray(wbinNextS);
      freeNextS  = DEPTHVAL - (wbinNextS - rbinSyncS);
   end

   // Read-pointer synchroniser: plain flop chain, no logic between stages.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < SYNCSTAGES; i++) begin
            syncR[i] <= {PW{1'b0}};
         end
      end else begin
         syncR[0] <= readPointerGray;
         for (int i = 1; i < SYNCSTAGES; i++) begin
            syncR[i] <= syncR[i-1];
         end
      end
   end

   // Binary and Gray write pointers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wbinR  <= {PW{1'b0}};
         wgrayR <= {PW{1'b0}};
      end else begin
         wbinR  <= wbinNextS;
         wgrayR <= wgrayNextS;
      end
   end

   // Status uses the post-write pointer, so full rises on the edge that takes the last slot.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         fullR       <= 1'b0;
         almostFullR <= 1'b0;
         freeCountR  <= DEPTHVAL;
      end else begin
         fullR       <= (wgrayNextS == (rgraySyncS ^ FULLMASK));
         almostFullR <= (freeNextS <= AFLEVEL);
         freeCountR  <= freeNextS;
      end
   end

endmodule

// File: tb/tb_async_fifo_write_control.sv
// Bench for async_fifo_write_control: occupancy model built from total write/read
// counts, per-cycle compare on the falling edge, plus hand-computed directed checks.
module tb_async_fifo_write_control;
   localparam int D    = 8;
   localparam int SYNC = 2;
   localparam int AFL  = 2;

   logic       clk = 1'b0;
   logic       resetN;
   logic       writeReq;
   logic [3:0] readPointerGray;
   logic       writeEn;
   logic [2:0] writeAddress;
   logic [3:0] writePointerGray;
   logic       full;
   logic       almostFull;
   logic [3:0] freeCount;

   int tests  = 0;
   int errors = 0;
   int rd     = 0;

   async_fifo_write_control #(
      .DATADEPTH(D), .SYNCSTAGES(SYNC), .ALMOSTFULLLEVEL(AFL)
   ) dut (
      .clk(clk), .resetN(resetN), .writeReq(writeReq),
      .readPointerGray(readPointerGray), .writeEn(writeEn),
      .writeAddress(writeAddress), .writePointerGray(writePointerGray),
      .full(full), .almostFull(almostFull), .freeCount(freeCount)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] gray(input int v);
      logic [3:0] b;
      b = 4'(v % (2 * D));
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic setRd(input int v);
      rd = v;
      readPointerGray = gray(v);
   endtask

   // Model: totals of writes and reads since reset; the status sees the read count
   // as it was SYNC edges earlier.
   int mW = 0, mCyc = 0, mFree = D;
   bit mFull = 1'b0, mAF = 1'b0;
   int rdAt [8192];
   int mAccS, mRsS, mFreeNextS;

   always_comb begin
      mAccS      = (writeReq && !mFull) ? 1 : 0;
      mRsS       = (mCyc >= SYNC) ? rdAt[(mCyc - SYNC) % 8192] : 0;
      mFreeNextS = D - (mW + mAccS - mRsS);
   end

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         mW <= 0; mCyc <= 0; mFree <= D; mFull <= 1'b0; mAF <= 1'b0;
      end else begin
         rdAt[mCyc % 8192] <= rd;
         mW    <= mW + mAccS;
         mFree <= mFreeNextS;
         mFull <= (mFreeNextS == 0);
         mAF   <= (mFreeNextS <= AFL);
         mCyc  <= mCyc + 1;
      end
   end

   int rstCount = 0, lastRst = 0;
   logic [3:0] prevGray = 4'd0;
   always @(negedge resetN) rstCount <= rstCount + 1;

   always @(negedge clk) begin
      chk("writeEn", int'(writeEn), (resetN && writeReq && !mFull) ? 1 : 0);
      chk("writeAddress", int'(writeAddress), mW % D);
      chk("writePointerGray", int'(writePointerGray), int'(gray(mW)));
      chk("full", int'(full), int'(mFull));
      chk("almostFull", int'(almostFull), int'(mAF));
      chk("freeCount", int'(freeCount), mFree);
      if (rstCount == lastRst && writePointerGray != prevGray)
         chk("grayOneBit", $countones(writePointerGray ^ prevGray), 1);
      prevGray <= writePointerGray;
      lastRst  <= rstCount;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int startW, wraps, fullSeen, prevAddr;
      resetN = 1'b0; writeReq = 1'b1; setRd(0);
      #7;
      chk("rst_writeEn", int'(writeEn), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_free", int'(freeCount), 8);
      chk("rst_gray", int'(writePointerGray), 0);
      chk("rst_af", int'(almostFull), 0);
      @(posedge clk); #1 resetN = 1'b1;
      #1 chk("rel_writeEn", int'(writeEn), 1);

      // Fill with the read pointer parked at 0.
      for (int i = 0; i <= D; i++) begin
         chk("fill_addr", int'(writeAddress), i % D);
         chk("fill_en", int'(writeEn), (i < D) ? 1 : 0);
         chk("fill_full", int'(full), (i == D) ? 1 : 0);
         chk("fill_free", int'(freeCount), D - i);
         chk("fill_af", int'(almostFull), (D - i <= AFL) ? 1 : 0);
         @(posedge clk); #2;
      end

      // One read becomes visible on the third edge.
      writeReq = 1'b0; setRd(1);
      chk("drain_gray_before", int'(writePointerGray), 4'b1100);
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk); #2;
         chk("drain_full", int'(full), (e < 3) ? 1 : 0);
      end
      chk("drain_free", int'(freeCount), 1);
      chk("drain_addr", int'(writeAddress), 0);
      writeReq = 1'b1;
      #1 chk("drain_en", int'(writeEn), 1);
      @(posedge clk); #2;
      chk("drain_refull", int'(full), 1);
      chk("drain_gray_after", int'(writePointerGray), 4'b1101);

      // Push held while full; the read lands on the same edge that clears full.
      setRd(2);
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk); #2;
         chk("sim_noWrite", int'(writeAddress), 1);
         chk("sim_full", int'(full), (e < 3) ? 1 : 0);
      end
      @(posedge clk); #2;
      chk("sim_accept", int'(writeAddress), 2);
      chk("sim_refull", int'(full), 1);

      writeReq = 1'b0;
      for (int c = 0; c < 20 && rd < mW; c++) begin
         setRd(rd + 1);
         @(posedge clk); #2;
      end
      repeat (3) @(posedge clk);
      #2;

      // Streaming with the reader trailing by three entries.
      startW = mW; wraps = 0; fullSeen = 0; prevAddr = int'(writeAddress);
      writeReq = 1'b1;
      for (int c = 0; c < 80 && (mW - startW) < 20; c++) begin
         @(posedge clk); #2;
         if (rd < mW - 3) setRd(rd + 1);
         if (full) fullSeen++;
         if (prevAddr == 7 && writeAddress == 3'd0) wraps++;
         prevAddr = int'(writeAddress);
      end
      chk("wrap_pushes", mW - startW, 20);
      chk("wrap_wraps", wraps, 2);
      chk("wrap_noFull", fullSeen, 0);

      // Random traffic: slow reader first (fills up), then fast reader.
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         writeReq = ($urandom_range(3) != 0);
         if (rd < mW && $urandom_range((c < 200) ? 3 : 1) == 0) setRd(rd + 1);
      end

      // Fresh reset, five writes, then an asynchronous reset pulse between edges.
      @(posedge clk); #1 resetN = 1'b0; writeReq = 1'b0; setRd(0);
      #1 resetN = 1'b1; writeReq = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("mid_addr5", int'(writeAddress), 5);
      resetN = 1'b0;
      #1;
      chk("mid_rst_addr", int'(writeAddress), 0);
      chk("mid_rst_gray", int'(writePointerGray), 0);
      chk("mid_rst_free", int'(freeCount), 8);
      chk("mid_rst_full", int'(full), 0);
      chk("mid_rst_en", int'(writeEn), 0);
      #1 resetN = 1'b1; setRd(0);
      #1;
      chk("mid_rel_en", int'(writeEn), 1);
      chk("mid_rel_addr", int'(writeAddress), 0);
      @(posedge clk); #2;
      chk("mid_next_addr", int'(writeAddress), 1);
      repeat (3) @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
